// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus the
// decode-facing valid/ready head port. master = fetch_queue, slave = environment.
interface fetch_queue_if #(
  parameter int XLEN = 32
) ();
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_data_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] instr_o;
  logic            fault_o;

  modport master (
    output mem_req_valid_o, mem_req_addr_o, valid_o, pc_o, instr_o, fault_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, ready_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o, valid_o, pc_o, instr_o, fault_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction prefetcher: issues word requests to a variable-latency
// memory, buffers responses in a FIFO and presents {pc, instr, fault} to decode.
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] BASE_ADDR       = XLEN'(32'h8000_0000),
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_queue_if.master   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_halted;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [TW-1:0]   r_tag_wptr, r_tag_rptr;

  logic [XLEN-1:0] r_pc_q    [DEPTH];
  logic [XLEN-1:0] r_instr_q [DEPTH];
  logic            r_fault_q [DEPTH];
  logic [XLEN-1:0] r_tag_q   [MAX_OUTSTANDING];

  logic            w_pc_fault, w_req_valid, w_req_fire;
  logic            w_rsp_drop, w_rsp_live, w_fault_push;
  logic            w_push, w_pop, w_head_vld;
  logic [31:0]     w_reserved;
  logic [XLEN-1:0] w_push_pc, w_push_instr;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots already promised to live in-flight responses count as occupied.
  assign w_reserved   = 32'(r_count) + 32'(r_outstanding) - 32'(r_drop_cnt);
  assign w_pc_fault   = (r_fetch_pc < BASE_ADDR) || (r_fetch_pc[1:0] != 2'b00);
  assign w_req_valid  = rst_n_i && !r_halted && !redirect_i && !w_pc_fault &&
                        (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                        (w_reserved < 32'(DEPTH));
  assign w_req_fire   = w_req_valid && bus.mem_req_ready_i;
  assign w_rsp_drop   = bus.mem_rsp_valid_i && (redirect_i || (r_drop_cnt != '0));
  assign w_rsp_live   = bus.mem_rsp_valid_i && !w_rsp_drop;
  // The fault entry waits until every older live response has landed.
  assign w_fault_push = !redirect_i && !r_halted && w_pc_fault &&
                        (r_outstanding == r_drop_cnt) && (32'(r_count) < 32'(DEPTH));
  assign w_push       = w_rsp_live || w_fault_push;
  assign w_head_vld   = (r_count != '0);
  assign w_pop        = w_head_vld && bus.ready_i && !redirect_i;
  assign w_push_pc    = w_fault_push ? r_fetch_pc : r_tag_q[r_tag_rptr];
  assign w_push_instr = w_fault_push ? '0 : bus.mem_rsp_data_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc    <= BASE_ADDR;
      r_halted      <= 1'b0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
    end else if (redirect_i) begin
      r_fetch_pc    <= redirect_pc_i;
      r_halted      <= 1'b0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= r_outstanding - OW'(bus.mem_rsp_valid_i);
      r_drop_cnt    <= r_outstanding - OW'(bus.mem_rsp_valid_i);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_tag_wptr <= tag_inc(r_tag_wptr);
      end
      if (w_rsp_live)   r_tag_rptr <= tag_inc(r_tag_rptr);
      if (w_rsp_drop)   r_drop_cnt <= r_drop_cnt - OW'(1);
      if (w_fault_push) r_halted   <= 1'b1;
      case ({w_req_fire, bus.mem_rsp_valid_i})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_q[r_wptr]    <= w_push_pc;
      r_instr_q[r_wptr] <= w_push_instr;
      r_fault_q[r_wptr] <= w_fault_push;
    end
    if (w_req_fire) r_tag_q[r_tag_wptr] <= r_fetch_pc;
  end

  assign bus.mem_req_valid_o = w_req_valid;
  assign bus.mem_req_addr_o  = r_fetch_pc - BASE_ADDR;
  assign bus.valid_o         = w_head_vld;
  assign bus.pc_o            = w_head_vld ? r_pc_q[r_rptr]    : '0;
  assign bus.instr_o         = w_head_vld ? r_instr_q[r_rptr] : '0;
  assign bus.fault_o         = w_head_vld && r_fault_q[r_rptr];

`ifndef NDEBUG
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(bus.mem_rsp_valid_i && (r_outstanding == '0)));
      assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: in-order variable-latency memory
// model plus an expected-stream queue derived from the redirect/reset target.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_queue_if #(.XLEN(XLEN)) bus ();

  fetch_queue #(.XLEN(XLEN), .BASE_ADDR(BASE), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .bus(bus.master)
  );

  always #5 clk = ~clk;

  ent_t exp_q[$];
  rsp_t mem_q[$];
  int   cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int   reqs_phase = 0, outs_phase = 0;
  int   checks = 0, failures = 0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit is_fault(input logic [31:0] pc);
    return (pc < BASE) || (pc[1:0] != 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected decode stream from a start pc: sequential words until the first faulting pc.
  task automatic gen_exp(input logic [31:0] start);
    logic [31:0] pc;
    bit stop;
    exp_q.delete();
    pc = start;
    stop = 1'b0;
    for (int i = 0; i < 1000 && !stop; i++) begin
      if (is_fault(pc)) begin
        exp_q.push_back('{pc, 32'h0, 1'b1});
        stop = 1'b1;
      end else begin
        exp_q.push_back('{pc, img(pc), 1'b0});
        pc = pc + 32'd4;
      end
    end
    reqs_phase = 0;
    outs_phase = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    step();
    redirect    = 1'b1;
    redirect_pc = pc;
    gen_exp(pc);
    step();
    redirect = 1'b0;
    sample();
    check("valid_after_redirect", {31'b0, bus.valid_o}, 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory response driver: in-order, one response per cycle at most.
  initial begin
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        last_due = 0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        bus.mem_rsp_valid_i = 1'b0;
      end
    end
  end

  // Monitor: memory request capture, request-hold rule and scoreboard pops.
  initial begin
    ent_t        e;
    int          due;
    bit          prev_pend;
    logic [31:0] prev_addr;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend && !redirect) begin
          check("req_hold_valid", {31'b0, bus.mem_req_valid_o}, 32'd1);
          check("req_hold_addr", bus.mem_req_addr_o, prev_addr);
        end
        prev_pend = bus.mem_req_valid_o && !bus.mem_req_ready_i;
        prev_addr = bus.mem_req_addr_o;
        if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
          reqs_phase++;
          due = cyc + $urandom_range(lat_min, lat_max);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_q.push_back('{img(BASE + bus.mem_req_addr_o), due});
        end
        if (bus.valid_o && bus.ready_i && !redirect) begin
          outs_phase++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual_pc=%h required=no_output", bus.pc_o);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", bus.pc_o, e.pc);
            check("out_instr", bus.instr_o, e.instr);
            check("out_fault", {31'b0, bus.fault_o}, {31'b0, e.fault});
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int          r;
    bus.ready_i         = 1'b1;
    bus.mem_req_ready_i = 1'b1;
    rst_n               = 1'b0;

    // Reset values and first-instruction latency with a zero-wait memory.
    repeat (3) @(posedge clk);
    sample();
    check("rst_valid_o", {31'b0, bus.valid_o}, 32'd0);
    check("rst_req_valid", {31'b0, bus.mem_req_valid_o}, 32'd0);
    check("rst_pc_o", bus.pc_o, 32'd0);
    check("rst_instr_o", bus.instr_o, 32'd0);
    check("rst_fault_o", {31'b0, bus.fault_o}, 32'd0);
    step();
    rst_n = 1'b1;
    gen_exp(BASE);
    sample();
    check("lat_c0_valid", {31'b0, bus.valid_o}, 32'd0);
    sample();
    check("lat_c1_valid", {31'b0, bus.valid_o}, 32'd0);
    sample();
    check("lat_c2_valid", {31'b0, bus.valid_o}, 32'd1);
    check("lat_c2_pc", bus.pc_o, BASE);
    check("lat_c2_instr", bus.instr_o, img(BASE));
    repeat (20) sample();
    check("throughput", outs_phase, 32'd21);

    // Backpressure: FIFO fills, requests stop, nothing lost.
    step();
    bus.ready_i = 1'b0;
    repeat (10) step();
    sample();
    check("full_valid_o", {31'b0, bus.valid_o}, 32'd1);
    check("full_req_valid", {31'b0, bus.mem_req_valid_o}, 32'd0);
    check("full_buffered", reqs_phase - outs_phase, DEPTH);
    step();
    bus.ready_i = 1'b1;
    repeat (10) step();

    // Redirect with 3-cycle latency and two requests in flight.
    lat_min = 3;
    lat_max = 3;
    repeat (10) step();
    do_redirect(BASE + 32'h100);
    repeat (15) step();
    sample();
    check("redir_progress", {31'b0, outs_phase > 0}, 32'd1);

    // Misaligned target: single fault entry, no requests, halted until redirect.
    lat_min = 1;
    lat_max = 1;
    do_redirect(BASE + 32'h102);
    repeat (10) step();
    sample();
    check("misal_reqs", reqs_phase, 32'd0);
    check("misal_outs", outs_phase, 32'd1);
    check("misal_halt_valid", {31'b0, bus.valid_o}, 32'd0);
    do_redirect(BASE);
    repeat (10) step();
    sample();
    check("resume_progress", {31'b0, outs_phase > 0}, 32'd1);

    // Target below BASE_ADDR.
    do_redirect(32'h7FFF_FFFC);
    repeat (10) step();
    sample();
    check("low_reqs", reqs_phase, 32'd0);
    check("low_outs", outs_phase, 32'd1);
    check("low_req_valid", {31'b0, bus.mem_req_valid_o}, 32'd0);
    do_redirect(BASE);
    repeat (10) step();

    // Asynchronous reset mid-operation.
    lat_min = 3;
    lat_max = 3;
    bus.ready_i = 1'b0;
    repeat (3) step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid_o", {31'b0, bus.valid_o}, 32'd0);
    check("arst_req_valid", {31'b0, bus.mem_req_valid_o}, 32'd0);
    check("arst_pc_o", bus.pc_o, 32'd0);
    check("arst_instr_o", bus.instr_o, 32'd0);
    check("arst_fault_o", {31'b0, bus.fault_o}, 32'd0);
    check("arst_addr", bus.mem_req_addr_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    lat_min = 1;
    lat_max = 1;
    bus.ready_i = 1'b1;
    rst_n = 1'b1;
    gen_exp(BASE);
    repeat (10) step();
    sample();
    check("post_rst_progress", {31'b0, outs_phase > 0}, 32'd1);

    // Randomized traffic: backpressure, memory stalls, latency and redirects.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      step();
      redirect            = 1'b0;
      bus.ready_i         = ($urandom_range(0, 3) != 0);
      bus.mem_req_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      tgt = BASE - 32'd4 * $urandom_range(1, 4);
        else if (r == 1) tgt = BASE + 32'd4 * $urandom_range(0, 255) + $urandom_range(1, 3);
        else             tgt = BASE + 32'd4 * $urandom_range(0, 1023);
        redirect    = 1'b1;
        redirect_pc = tgt;
        gen_exp(tgt);
      end
    end
    step();
    redirect            = 1'b0;
    bus.ready_i         = 1'b1;
    bus.mem_req_ready_i = 1'b1;
    do_redirect(BASE + 32'h40);
    repeat (15) step();
    sample();
    check("final_progress", {31'b0, outs_phase > 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
